// File: rtl/scene_object_renderer_pkg.sv
// render_pkg: shared types and constants for the scene object renderer.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
package render_pkg;

  localparam int COORD_W    = 11;
  localparam int NUM_OBJ    = 3;
  localparam int NUM_FIELDS = 5;

  // Word position of each field inside an object's 5-word slot on the state bus
  localparam int F_IMG = 0;
  localparam int F_X   = 1;
  localparam int F_Y   = 2;
  localparam int F_W   = 3;
  localparam int F_H   = 4;

  // Bit position of each object pair inside collision_mask
  localparam int NUM_PAIRS = 3;
  localparam int P01       = 0;
  localparam int P02       = 1;
  localparam int P12       = 2;

  typedef struct packed {
    logic [COORD_W-1:0] img_id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } obj_state_t;

endpackage

// File: rtl/scene_object_renderer_if.sv
// scene_object_renderer_if: object-state bus, pixel stream and draw-result bundle.
// Latency: n/a (wiring only).
// Backpressure: none; the pixel stream is free-running, one pixel per cycle.
interface scene_object_renderer_if;
  import render_pkg::*;

  logic                                            frame_start;
  logic [0:NUM_OBJ*NUM_FIELDS-1][0:COORD_W-1]      current_state;
  logic                                            pixel_valid;
  logic [COORD_W-1:0]                              pixelX;
  logic [COORD_W-1:0]                              pixelY;
  logic                                            drawing_request;
  logic [1:0]                                      obj_idx;
  logic [COORD_W-1:0]                              img_id;
  logic [COORD_W-1:0]                              offsetX;
  logic [COORD_W-1:0]                              offsetY;
  logic [NUM_PAIRS-1:0]                            collision_mask;

  // Producer side: scan logic and object controllers
  modport master (
    output frame_start, current_state, pixel_valid, pixelX, pixelY,
    input  drawing_request, obj_idx, img_id, offsetX, offsetY, collision_mask
  );

  // Renderer side
  modport slave (
    input  frame_start, current_state, pixel_valid, pixelX, pixelY,
    output drawing_request, obj_idx, img_id, offsetX, offsetY, collision_mask
  );

endinterface

// File: rtl/scene_object_renderer_obj_hit_unit.sv
// obj_hit_unit: rectangle hit test of one pixel against one object, plus offset.
// Latency: combinational; the parent registers the results.
// Backpressure: none. SCENE_RENDER_CLIP_EN clamps the right edge to SCREEN_W.
module obj_hit_unit
  import render_pkg::*;
#(
  parameter int SCREEN_W = 640
) (
  input  obj_state_t         i_obj,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  output logic               o_hit,
  output logic [COORD_W-1:0] o_dx,
  output logic [COORD_W-1:0] o_dy,
  output logic [COORD_W-1:0] o_img_id
);

`ifdef SCENE_RENDER_CLIP_EN
  localparam bit LP_CLIP_EN = 1'b1;
`else
  localparam bit LP_CLIP_EN = 1'b0;
`endif
  localparam logic [COORD_W:0] LP_SCREEN_W = (COORD_W+1)'(SCREEN_W);

  logic             w_en;
  logic [COORD_W:0] w_px;
  logic [COORD_W:0] w_py;
  logic [COORD_W:0] w_x0;
  logic [COORD_W:0] w_y0;
  logic [COORD_W:0] w_x_end;
  logic [COORD_W:0] w_y_end;

  // Edges are computed one bit wider so x+width never wraps; right/bottom exclusive
  always_comb begin
    w_en    = (i_obj.width != '0) && (i_obj.height != '0);
    w_px    = {1'b0, i_px};
    w_py    = {1'b0, i_py};
    w_x0    = {1'b0, i_obj.x};
    w_y0    = {1'b0, i_obj.y};
    w_x_end = w_x0 + {1'b0, i_obj.width};
    w_y_end = w_y0 + {1'b0, i_obj.height};
    // Clamping the right edge also rejects every pixel at or past the screen edge
    if (LP_CLIP_EN && (w_x_end > LP_SCREEN_W)) begin
      w_x_end = LP_SCREEN_W;
    end
    o_hit    = w_en && (w_px >= w_x0) && (w_px < w_x_end)
                    && (w_py >= w_y0) && (w_py < w_y_end);
    o_dx     = i_px - i_obj.x;
    o_dy     = i_py - i_obj.y;
    // Forwarded so the parent can pipeline the id alongside the hit
    o_img_id = i_obj.img_id;
  end

endmodule

// File: rtl/scene_object_renderer.sv
// scene_object_renderer: resolves which object covers each pixel and flags pair overlaps.
// Latency: 2 cycles pixel -> draw outputs; collision_mask visible the cycle after frame_start.
// Backpressure: none, one pixel per cycle. Option SCENE_RENDER_CLIP_EN clips hits at SCREEN_W.
module scene_object_renderer #(
  parameter int NUM_OBJ  = 3,
  parameter int SCREEN_W = 640
) (
  input logic                    clk,
  input logic                    reset,
  scene_object_renderer_if.slave bus
);
  import render_pkg::*;

  obj_state_t           r_shadow [NUM_OBJ];

  logic [NUM_OBJ-1:0]   w_hit;
  logic [COORD_W-1:0]   w_dx     [NUM_OBJ];
  logic [COORD_W-1:0]   w_dy     [NUM_OBJ];
  logic [COORD_W-1:0]   w_img    [NUM_OBJ];

  logic [NUM_OBJ-1:0]   r_s1_hit;
  logic [COORD_W-1:0]   r_s1_dx  [NUM_OBJ];
  logic [COORD_W-1:0]   r_s1_dy  [NUM_OBJ];
  logic [COORD_W-1:0]   r_s1_img [NUM_OBJ];
  logic                 r_s1_vld;

  logic [NUM_OBJ-1:0]   w_s2_hit;
  logic                 w_sel_vld;
  logic [1:0]           w_sel_idx;
  logic [COORD_W-1:0]   w_sel_img;
  logic [COORD_W-1:0]   w_sel_dx;
  logic [COORD_W-1:0]   w_sel_dy;
  logic [NUM_PAIRS-1:0] w_pair;
  logic [NUM_PAIRS-1:0] r_acc;

  // Snapshot the object state bus at frame start; all hit tests use this copy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_shadow[k] <= '0;
      end
    end else if (bus.frame_start) begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_shadow[k].img_id <= bus.current_state[NUM_FIELDS*k + F_IMG];
        r_shadow[k].x      <= bus.current_state[NUM_FIELDS*k + F_X];
        r_shadow[k].y      <= bus.current_state[NUM_FIELDS*k + F_Y];
        r_shadow[k].width  <= bus.current_state[NUM_FIELDS*k + F_W];
        r_shadow[k].height <= bus.current_state[NUM_FIELDS*k + F_H];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OBJ; g++) begin : g_hit
      obj_hit_unit #(
        .SCREEN_W (SCREEN_W)
      ) u_hit (
        .i_obj    (r_shadow[g]),
        .i_px     (bus.pixelX),
        .i_py     (bus.pixelY),
        .o_hit    (w_hit[g]),
        .o_dx     (w_dx[g]),
        .o_dy     (w_dy[g]),
        .o_img_id (w_img[g])
      );
    end
  endgenerate

  // Stage 1: register raw per-object results; img_id travels with the pixel so a
  // snapshot taken while the pixel is in flight cannot change its reported id
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_hit <= '0;
      r_s1_vld <= 1'b0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_s1_dx[k]  <= '0;
        r_s1_dy[k]  <= '0;
        r_s1_img[k] <= '0;
      end
    end else begin
      r_s1_hit <= w_hit;
      r_s1_vld <= bus.pixel_valid;
      for (int k = 0; k < NUM_OBJ; k++) begin
        r_s1_dx[k]  <= w_dx[k];
        r_s1_dy[k]  <= w_dy[k];
        r_s1_img[k] <= w_img[k];
      end
    end
  end

  // Stage 2 select: invalid pixels hit nothing; lowest index wins; misses give zeros
  always_comb begin
    w_s2_hit  = r_s1_hit & {NUM_OBJ{r_s1_vld}};
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    w_sel_img = '0;
    w_sel_dx  = '0;
    w_sel_dy  = '0;
    for (int k = NUM_OBJ - 1; k >= 0; k--) begin
      if (w_s2_hit[k]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = 2'(k);
        w_sel_img = r_s1_img[k];
        w_sel_dx  = r_s1_dx[k];
        w_sel_dy  = r_s1_dy[k];
      end
    end
    w_pair      = '0;
    w_pair[P01] = w_s2_hit[0] & w_s2_hit[1];
    w_pair[P02] = w_s2_hit[0] & w_s2_hit[2];
    w_pair[P12] = w_s2_hit[1] & w_s2_hit[2];
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.drawing_request <= 1'b0;
      bus.obj_idx         <= '0;
      bus.img_id          <= '0;
      bus.offsetX         <= '0;
      bus.offsetY         <= '0;
    end else begin
      bus.drawing_request <= w_sel_vld;
      bus.obj_idx         <= w_sel_idx;
      bus.img_id          <= w_sel_img;
      bus.offsetX         <= w_sel_dx;
      bus.offsetY         <= w_sel_dy;
    end
  end

  // Collision accumulate; a pair hit landing on the frame_start edge belongs to the
  // frame being published, then the accumulator restarts empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc              <= '0;
      bus.collision_mask <= '0;
    end else if (bus.frame_start) begin
      bus.collision_mask <= r_acc | w_pair;
      r_acc              <= '0;
    end else begin
      r_acc              <= r_acc | w_pair;
    end
  end

endmodule

// File: tb/tb_scene_object_renderer.sv
// tb_scene_object_renderer: directed vectors, literal checks and a per-cycle reference model.
// Latency: model delays results by two clocks to line up with the DUT outputs.
// Backpressure: none; the bench drives one pixel per cycle at most.
module tb_scene_object_renderer;
  import render_pkg::*;

  localparam int SW = 640;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  scene_object_renderer_if bus_if ();

  scene_object_renderer #(
    .NUM_OBJ  (3),
    .SCREEN_W (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       dr;
    int       idx;
    int       img;
    int       ox;
    int       oy;
    bit [2:0] pairs;
  } res_t;

  int s_img [3];
  int s_x   [3];
  int s_y   [3];
  int s_w   [3];
  int s_h   [3];

  res_t     m_s1;
  res_t     m_out;
  bit [2:0] m_acc;
  bit [2:0] m_mask;
  bit       m_ready = 1'b0;

  function automatic res_t zero_res();
    res_t r;
    r.dr = 0; r.idx = 0; r.img = 0; r.ox = 0; r.oy = 0; r.pairs = 3'b000;
    return r;
  endfunction

  // Rectangle coverage straight from the rules: right/bottom edges exclusive
  function automatic res_t resolve(input int px, input int py, input bit v);
    res_t r;
    bit   h [3];
    int   xe;
    r = zero_res();
    for (int k = 0; k < 3; k++) begin
      xe = s_x[k] + s_w[k];
`ifdef SCENE_RENDER_CLIP_EN
      if (xe > SW) xe = SW;
`endif
      h[k] = v && (s_w[k] != 0) && (s_h[k] != 0) &&
             (px >= s_x[k]) && (px < xe) &&
             (py >= s_y[k]) && (py < s_y[k] + s_h[k]);
    end
    for (int k = 0; k < 3; k++) begin
      if (h[k] && !r.dr) begin
        r.dr  = 1;
        r.idx = k;
        r.img = s_img[k];
        r.ox  = (px - s_x[k]) & 32'h7FF;
        r.oy  = (py - s_y[k]) & 32'h7FF;
      end
    end
    r.pairs = {h[1] & h[2], h[0] & h[2], h[0] & h[1]};
    return r;
  endfunction

  always @(posedge clk) begin
    res_t r;
    if (reset) begin
      m_s1    = zero_res();
      m_out   = zero_res();
      m_acc   = 3'b000;
      m_mask  = 3'b000;
      for (int k = 0; k < 3; k++) begin
        s_img[k] = 0; s_x[k] = 0; s_y[k] = 0; s_w[k] = 0; s_h[k] = 0;
      end
      m_ready = 1'b1;
    end else begin
      r = resolve(int'(bus_if.pixelX), int'(bus_if.pixelY), bus_if.pixel_valid);
      if (bus_if.frame_start) begin
        m_mask = m_acc | m_s1.pairs;
        m_acc  = 3'b000;
        for (int k = 0; k < 3; k++) begin
          s_img[k] = int'(bus_if.current_state[5*k + 0]);
          s_x[k]   = int'(bus_if.current_state[5*k + 1]);
          s_y[k]   = int'(bus_if.current_state[5*k + 2]);
          s_w[k]   = int'(bus_if.current_state[5*k + 3]);
          s_h[k]   = int'(bus_if.current_state[5*k + 4]);
        end
      end else begin
        m_acc = m_acc | m_s1.pairs;
      end
      m_out = m_s1;
      m_s1  = r;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_ready) begin
      chk("cyc_drawing_request", bus_if.drawing_request, m_out.dr);
      chk("cyc_obj_idx",         bus_if.obj_idx,         m_out.idx);
      chk("cyc_img_id",          bus_if.img_id,          m_out.img);
      chk("cyc_offsetX",         bus_if.offsetX,         m_out.ox);
      chk("cyc_offsetY",         bus_if.offsetY,         m_out.oy);
      chk("cyc_collision_mask",  bus_if.collision_mask,  m_mask);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_obj(input int k, input int img, input int x, input int y,
                         input int w, input int h);
    bus_if.current_state[5*k + F_IMG] = 11'(img);
    bus_if.current_state[5*k + F_X]   = 11'(x);
    bus_if.current_state[5*k + F_Y]   = 11'(y);
    bus_if.current_state[5*k + F_W]   = 11'(w);
    bus_if.current_state[5*k + F_H]   = 11'(h);
  endtask

  task automatic frame();
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input bit v);
    bus_if.pixelX      = 11'(x);
    bus_if.pixelY      = 11'(y);
    bus_if.pixel_valid = v;
    tick();
    bus_if.pixel_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input bit dr, input int idx, input int img,
                         input int ox, input int oy);
    chk({nm, "_dr"},  bus_if.drawing_request, dr);
    chk({nm, "_idx"}, bus_if.obj_idx,         idx);
    chk({nm, "_img"}, bus_if.img_id,          img);
    chk({nm, "_ox"},  bus_if.offsetX,         ox);
    chk({nm, "_oy"},  bus_if.offsetY,         oy);
  endtask

  // Present one pixel and check the hand-computed result two clocks later
  task automatic pix_lit(input string nm, input int x, input int y, input bit dr,
                         input int idx, input int img, input int ox, input int oy);
    pix(x, y, 1'b1);
    tick();
    chk_out(nm, dr, idx, img, ox, oy);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus_if.frame_start   = 1'b0;
    bus_if.current_state = '0;
    bus_if.pixel_valid   = 1'b0;
    bus_if.pixelX        = '0;
    bus_if.pixelY        = '0;
    reset = 1'b1;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset_mask", bus_if.collision_mask, 3'b000);
    reset = 1'b0;

    // Single object, edge inclusivity
    set_obj(0, 0, 256, 380, 32, 36);
    set_obj(1, 5, 256, 380, 0, 36);
    set_obj(2, 6, 400, 400, 10, 0);
    frame();
    pix_lit("t1_origin", 256, 380, 1, 0, 0, 0, 0);
    pix_lit("t1_corner", 287, 415, 1, 0, 0, 31, 35);
    pix_lit("t1_redge",  288, 380, 0, 0, 0, 0, 0);
    pix_lit("t1_bedge",  256, 416, 0, 0, 0, 0, 0);
    pix_lit("t1_left",   255, 380, 0, 0, 0, 0, 0);
    pix_lit("t1_dis_h0", 400, 400, 0, 0, 0, 0, 0);
    pix(260, 390, 1'b0);
    tick();
    chk_out("t1_invalid", 0, 0, 0, 0, 0);

    // Overlap of objects 0 and 1
    set_obj(0, 7, 100, 100, 20, 20);
    set_obj(1, 9, 110, 110, 20, 20);
    set_obj(2, 0, 0, 0, 0, 0);
    frame();
    chk("t2_mask_prev", bus_if.collision_mask, 3'b000);
    pix_lit("t2_overlap", 115, 115, 1, 0, 7, 15, 15);
    pix_lit("t2_obj1",    125, 125, 1, 1, 9, 15, 15);
    pix_lit("t2_redge1",  130, 115, 0, 0, 0, 0, 0);
    chk("t2_mask_before_pub", bus_if.collision_mask, 3'b000);
    frame();
    chk("t2_mask_pub", bus_if.collision_mask, 3'b001);
    for (int i = 0; i < 4; i++) pix(50 + i, 50, 1'b1);
    tick();
    chk("t2_mask_hold", bus_if.collision_mask, 3'b001);
    frame();
    chk("t2_mask_next", bus_if.collision_mask, 3'b000);

    // Triple overlap sets every pair bit
    set_obj(0, 1, 206, 206, 2, 2);
    set_obj(1, 3, 200, 200, 10, 10);
    set_obj(2, 4, 205, 205, 10, 10);
    frame();
    pix_lit("t3_triple", 207, 207, 1, 0, 1, 1, 1);
    pix_lit("t3_obj2",   212, 212, 1, 2, 4, 7, 7);
    frame();
    chk("t3_mask", bus_if.collision_mask, 3'b111);
    pix_lit("t3_pair12", 209, 209, 1, 1, 3, 9, 9);
    frame();
    chk("t3_mask12", bus_if.collision_mask, 3'b100);

    // Mid-frame state change waits for the next snapshot
    set_obj(0, 2, 50, 60, 10, 10);
    set_obj(1, 0, 0, 0, 0, 0);
    set_obj(2, 0, 0, 0, 0, 0);
    frame();
    set_obj(0, 2, 300, 300, 10, 10);
    pix_lit("t4_old_pos", 55, 65, 1, 0, 2, 5, 5);
    pix_lit("t4_new_pre", 305, 305, 0, 0, 0, 0, 0);
    frame();
    pix_lit("t4_new_pos", 305, 305, 1, 0, 2, 5, 5);
    pix_lit("t4_old_gone", 55, 65, 0, 0, 0, 0, 0);

    // Pixel coincident with frame_start uses the old snapshot
    set_obj(0, 8, 500, 100, 10, 10);
    bus_if.pixelX      = 11'd305;
    bus_if.pixelY      = 11'd305;
    bus_if.pixel_valid = 1'b1;
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.pixel_valid = 1'b0;
    bus_if.frame_start = 1'b0;
    tick();
    chk_out("t5_same_cycle", 1, 0, 2, 5, 5);
    pix_lit("t5_new_snap", 505, 103, 1, 0, 8, 5, 3);

    // Collision in stage 2 on the frame_start edge counts for the published frame
    set_obj(0, 1, 10, 10, 8, 8);
    set_obj(1, 2, 12, 12, 8, 8);
    frame();
    pix(14, 14, 1'b1);
    frame();
    chk("t6_edge_pub", bus_if.collision_mask, 3'b001);
    frame();
    chk("t6_edge_next", bus_if.collision_mask, 3'b000);

    // Reset mid-scan drops in-flight pixels and clears the accumulator
    pix(14, 14, 1'b1);
    tick();
    pix(15, 15, 1'b1);
    reset = 1'b1;
    tick();
    chk_out("t7_reset", 0, 0, 0, 0, 0);
    chk("t7_reset_mask", bus_if.collision_mask, 3'b000);
    reset = 1'b0;
    frame();
    chk("t7_mask_after", bus_if.collision_mask, 3'b000);
    pix_lit("t7_reloaded", 14, 14, 1, 0, 1, 4, 4);

    // Right-hand screen edge
    set_obj(0, 1, 630, 50, 32, 10);
    set_obj(1, 0, 0, 0, 0, 0);
    set_obj(2, 0, 0, 0, 0, 0);
    frame();
`ifdef SCENE_RENDER_CLIP_EN
    pix_lit("t8_clip", 645, 55, 0, 0, 0, 0, 0);
`else
    pix_lit("t8_noclip", 645, 55, 1, 0, 1, 15, 5);
`endif
    pix_lit("t8_inside", 635, 55, 1, 0, 1, 5, 5);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
